// File: rtl/proc_pkg.sv
// Shared types for the 16-bit processor: FSM state codes, opcodes, ALU selects, control bundle.
// The decode_ctrl helper maps a state plus instruction to the datapath control word.
package proc_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;

  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_w_en;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra_addr;
    logic [3:0] rf_rb_addr;
    logic [2:0] alu_s0;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] ir);
    ctrl_t c;
    c = '0;
    case (st)
      S_LOAD_A, S_LOAD_B: begin
        c.d_addr    = ir[11:4];
        c.rf_s      = 1'b1;
        c.rf_w_addr = ir[3:0];
        // first load cycle only addresses RAM; write lands once q has settled
        c.rf_w_en   = (st == S_LOAD_B);
      end
      S_STORE: begin
        c.d_addr     = ir[11:4];
        c.rf_ra_addr = ir[3:0];
        c.d_w_en     = 1'b1;
      end
      S_ADD, S_SUB: begin
        c.rf_ra_addr = ir[11:8];
        c.rf_rb_addr = ir[7:4];
        c.rf_w_addr  = ir[3:0];
        c.alu_s0     = (st == S_ADD) ? ALU_ADD : ALU_SUB;
        c.rf_w_en    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous clear, increment enable, wraps silently at 2**PC_W.
// Latency: new value visible one cycle after clr/inc; no backpressure.
module program_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (clr)
      pc <= '0;
    else if (inc)
      pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller: owns PC and IR, drives all datapath controls as registered Moore outputs.
// Latency: 3 cycles per instruction from Fetch (4 for LOAD); no backpressure, HALT freezes until reset.
module control_unit
  import proc_pkg::*;
#(
  parameter int PC_W  = 7,
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [WIDTH-1:0] I_Data,
  output logic [PC_W-1:0]  PC_Addr,
  output logic [WIDTH-1:0] IR_Out,
  output logic [7:0]       D_Addr,
  output logic             D_W_en,
  output logic             RF_s,
  output logic [3:0]       RF_W_Addr,
  output logic             RF_W_en,
  output logic [3:0]       RF_Ra_Addr,
  output logic [3:0]       RF_Rb_Addr,
  output logic [2:0]       ALU_s0,
  output logic [3:0]       OutState
);

  state_t           state, next_state;
  logic [WIDTH-1:0] ir;
  ctrl_t            ctrl;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk (Clock),
    .clr (!ResetN),
    .inc (state == S_FETCH),
    .pc  (PC_Addr)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (ir[15:12])
          OP_LOAD:  next_state = S_LOAD_A;
          OP_STORE: next_state = S_STORE;
          OP_ADD:   next_state = S_ADD;
          OP_SUB:   next_state = S_SUB;
          OP_HALT:  next_state = S_HALT;
          default:  next_state = S_NOOP;
        endcase
      end
      S_LOAD_A: next_state = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_INIT;
    endcase
  end

  // Controls are decoded from the next state so they line up with OutState;
  // IR only changes on the way into Decode, where all controls are zero anyway.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state <= S_INIT;
      ir    <= '0;
      ctrl  <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH)
        ir <= I_Data;
      ctrl <= decode_ctrl(next_state, ir[15:0]);
    end
  end

  assign IR_Out     = ir;
  assign OutState   = state;
  assign D_Addr     = ctrl.d_addr;
  assign D_W_en     = ctrl.d_w_en;
  assign RF_s       = ctrl.rf_s;
  assign RF_W_Addr  = ctrl.rf_w_addr;
  assign RF_W_en    = ctrl.rf_w_en;
  assign RF_Ra_Addr = ctrl.rf_ra_addr;
  assign RF_Rb_Addr = ctrl.rf_rb_addr;
  assign ALU_s0     = ctrl.alu_s0;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a synchronous ROM model feeding I_Data.
module tb_control_unit;

  logic        Clock;
  logic        ResetN;
  logic [15:0] I_Data;
  logic [6:0]  PC_Addr;
  logic [15:0] IR_Out;
  logic [7:0]  D_Addr;
  logic        D_W_en;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [3:0]  OutState;

  logic [15:0] rom [0:127];
  int total;
  int bad;

  control_unit #(.PC_W(7), .WIDTH(16)) dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .I_Data     (I_Data),
    .PC_Addr    (PC_Addr),
    .IR_Out     (IR_Out),
    .D_Addr     (D_Addr),
    .D_W_en     (D_W_en),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .OutState   (OutState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) I_Data <= rom[PC_Addr];

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      total++;
      if ({PC_Addr, IR_Out, D_Addr, D_W_en, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr,
           RF_Rb_Addr, ALU_s0, OutState} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got state=%0d pc=%0d ir=%h want all zero",
                 i, OutState, PC_Addr, IR_Out);
      end
    end
    ResetN = 1'b1;
    step(1);
    total++;
    if ({OutState, PC_Addr} !== {4'd1, 7'd0}) begin
      bad++;
      $display("FAIL first_fetch got state=%0d pc=%0d want state=1 pc=0", OutState, PC_Addr);
    end
    step(1);
    total++;
    if ({OutState, PC_Addr, IR_Out} !== {4'd2, 7'd1, 16'h2005}) begin
      bad++;
      $display("FAIL first_decode got state=%0d pc=%0d ir=%h want state=2 pc=1 ir=2005",
               OutState, PC_Addr, IR_Out);
    end
  endtask

  task automatic test_load;
    step(1);
    total++;
    if ({OutState, D_Addr, RF_s, RF_W_en, RF_W_Addr, D_W_en} !==
        {4'd4, 8'h00, 1'b1, 1'b0, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL load_a got state=%0d daddr=%h rfs=%b wen=%b waddr=%0d want 4/00/1/0/5",
               OutState, D_Addr, RF_s, RF_W_en, RF_W_Addr);
    end
    step(1);
    total++;
    if ({OutState, D_Addr, RF_s, RF_W_en, RF_W_Addr, D_W_en} !==
        {4'd5, 8'h00, 1'b1, 1'b1, 4'd5, 1'b0}) begin
      bad++;
      $display("FAIL load_b got state=%0d daddr=%h rfs=%b wen=%b waddr=%0d want 5/00/1/1/5",
               OutState, D_Addr, RF_s, RF_W_en, RF_W_Addr);
    end
    step(1);
    total++;
    if ({OutState, RF_W_en, PC_Addr} !== {4'd1, 1'b0, 7'd1}) begin
      bad++;
      $display("FAIL load_return got state=%0d wen=%b pc=%0d want 1/0/1", OutState, RF_W_en, PC_Addr);
    end
  endtask

  task automatic test_add_sub;
    step(2);
    total++;
    if ({OutState, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_en, RF_s, D_W_en} !==
        {4'd7, 4'd0, 4'd1, 4'd2, 3'd1, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add got state=%0d ra=%0d rb=%0d w=%0d alu=%0d wen=%b want 7/0/1/2/1/1",
               OutState, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_en);
    end
    step(1);
    total++;
    if ({OutState, RF_W_en} !== {4'd1, 1'b0}) begin
      bad++;
      $display("FAIL add_pulse got state=%0d wen=%b want 1/0", OutState, RF_W_en);
    end
    step(2);
    total++;
    if ({OutState, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_en} !==
        {4'd8, 4'd0, 4'd1, 4'd3, 3'd2, 1'b1}) begin
      bad++;
      $display("FAIL sub got state=%0d ra=%0d rb=%0d w=%0d alu=%0d wen=%b want 8/0/1/3/2/1",
               OutState, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, ALU_s0, RF_W_en);
    end
  endtask

  task automatic test_store;
    step(3);
    total++;
    if ({OutState, D_Addr, RF_Ra_Addr, D_W_en, RF_W_en} !== {4'd6, 8'h02, 4'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL store got state=%0d daddr=%h ra=%0d dwen=%b rfwen=%b want 6/02/2/1/0",
               OutState, D_Addr, RF_Ra_Addr, D_W_en, RF_W_en);
    end
    step(1);
    total++;
    if ({OutState, D_W_en} !== {4'd1, 1'b0}) begin
      bad++;
      $display("FAIL store_pulse got state=%0d dwen=%b want 1/0", OutState, D_W_en);
    end
  endtask

  task automatic test_undef_halt;
    step(2);
    total++;
    if ({OutState, D_W_en, RF_W_en} !== {4'd3, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL undef_as_noop got state=%0d want 3", OutState);
    end
    step(3);
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({OutState, PC_Addr, IR_Out, D_W_en, RF_W_en} !== {4'd9, 7'd6, 16'h5000, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL halt_hold cycle=%0d got state=%0d pc=%0d ir=%h want 9/6/5000",
                 i, OutState, PC_Addr, IR_Out);
      end
      step(1);
    end
    ResetN = 1'b0;
    step(1);
    total++;
    if ({OutState, PC_Addr, IR_Out} !== {4'd0, 7'd0, 16'h0000}) begin
      bad++;
      $display("FAIL halt_reset got state=%0d pc=%0d ir=%h want 0/0/0000", OutState, PC_Addr, IR_Out);
    end
  endtask

  task automatic test_reset_mid_load;
    ResetN = 1'b1;
    step(3);
    total++;
    if (OutState !== 4'd4) begin
      bad++;
      $display("FAIL midload_enter got state=%0d want 4", OutState);
    end
    ResetN = 1'b0;
    step(1);
    total++;
    if ({OutState, RF_W_en, PC_Addr, RF_s} !== {4'd0, 1'b0, 7'd0, 1'b0}) begin
      bad++;
      $display("FAIL midload_reset got state=%0d wen=%b pc=%0d rfs=%b want 0/0/0/0",
               OutState, RF_W_en, PC_Addr, RF_s);
    end
  endtask

  task automatic test_pc_wrap;
    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
    step(1);
    ResetN = 1'b1;
    step(1);
    for (int i = 0; i < 128; i++) begin
      total++;
      if ({OutState, PC_Addr} !== {4'd1, 7'(i)}) begin
        bad++;
        $display("FAIL wrap_fetch n=%0d got state=%0d pc=%0d want 1/%0d", i, OutState, PC_Addr, i);
      end
      step(i == 127 ? 1 : 3);
    end
    total++;
    if ({OutState, PC_Addr} !== {4'd2, 7'd0}) begin
      bad++;
      $display("FAIL wrap_to_zero got state=%0d pc=%0d want 2/0", OutState, PC_Addr);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    ResetN = 1'b0;
    for (int a = 0; a < 128; a++) rom[a] = 16'h0000;
    rom[0] = 16'h2005;
    rom[1] = 16'h3012;
    rom[2] = 16'h4013;
    rom[3] = 16'h1022;
    rom[4] = 16'hF000;
    rom[5] = 16'h5000;
    test_reset;
    test_load;
    test_add_sub;
    test_store;
    test_undef_halt;
    test_reset_mid_load;
    test_pc_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
